// File: rtl/expr_lane_if.sv
// expr_lane_if: valid/ready operand beat in, result beat out, for expr_lane_pipe.
interface expr_lane_if #(parameter int LANES = 6, parameter int W = 6);
    logic                     in_valid, in_ready;
    logic [LANES*W-1:0]       a, b;
    logic [LANES*3-1:0]       op;
    logic                     out_valid, out_ready;
    logic [LANES*(W+1)-1:0]   y;
    modport master (output in_valid, a, b, op, out_ready, input in_ready, out_valid, y);
    modport slave  (input in_valid, a, b, op, out_ready, output in_ready, out_valid, y);
endinterface

// File: rtl/expr_lane_pipe.sv
// expr_lane_pipe: 2-stage multi-lane mixed-signedness ALU with valid/ready handshake
// and a running signature/transfer count of delivered results.
module expr_lane_pipe #(
    parameter int               LANES       = 6,
    parameter int               W           = 6,
    parameter logic [LANES-1:0] SIGNED_MASK = 6'b111000,
    parameter int               SIG_W       = 32,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    expr_lane_if.slave       bus,
    input  logic             clear_i,
    output logic [SIG_W-1:0] sig_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int YW  = LANES*(W+1);
    localparam int NCH = (YW+SIG_W-1)/SIG_W;

    logic                   s1_v_q, s2_v_q;
    logic [LANES*W-1:0]     a_q, b_q;
    logic [LANES*3-1:0]     op_q;
    logic [YW-1:0]          y_q, y_d;
    logic [SIG_W-1:0]       sig_q, sig_d, fold;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NCH*SIG_W-1:0]   y_pad;
    logic                   s1_adv, s2_adv, xfer;

    assign s2_adv        = !s2_v_q || bus.out_ready;
    assign s1_adv        = !s1_v_q || s2_adv;
    assign xfer          = s2_v_q && bus.out_ready;
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_v_q;
    assign bus.y         = y_q;
    assign sig_o         = sig_q;
    assign count_o       = cnt_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [W:0] ea, eb, r;
        logic [2:0] sh;
        logic       lt;
        always_comb begin
            ea = SIGNED_MASK[g] ? {a_q[g*W+W-1], a_q[g*W +: W]} : {1'b0, a_q[g*W +: W]};
            eb = SIGNED_MASK[g] ? {b_q[g*W+W-1], b_q[g*W +: W]} : {1'b0, b_q[g*W +: W]};
            sh = b_q[g*W +: 3];
            lt = SIGNED_MASK[g] ? ($signed(ea) < $signed(eb)) : (ea < eb);
            case (op_q[g*3 +: 3])
                3'd0:    r = ea + eb;
                3'd1:    r = ea - eb;
                3'd2:    r = ea & eb;
                3'd3:    r = ~(ea ^ eb);
                3'd4:    r = ea << sh;
                // $unsigned keeps the arithmetic shift self-determined inside the ternary
                3'd5:    r = SIGNED_MASK[g] ? $unsigned($signed(ea) >>> sh) : ea >> sh;
                3'd6:    r = {{W{1'b0}}, lt};
                default: r = {{W{1'b0}}, ~|(a_q[g*W +: W] ^ b_q[g*W +: W])};
            endcase
        end
        assign y_d[g*(W+1) +: W+1] = r;
    end

    always_comb begin
        y_pad = '0;
        y_pad[YW-1:0] = y_q;
        fold = '0;
        for (int i = 0; i < NCH; i++) fold = fold ^ y_pad[i*SIG_W +: SIG_W];
        sig_d = clear_i ? '0 : xfer ? {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ fold : sig_q;
        cnt_d = clear_i ? '0 : (xfer && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            y_q    <= '0;
            sig_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (s1_adv) s1_v_q <= bus.in_valid;
            if (s1_adv && bus.in_valid) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                op_q <= bus.op;
            end
            if (s2_adv) s2_v_q <= s1_v_q;
            if (s2_adv && s1_v_q) y_q <= y_d;
            sig_q <= sig_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_expr_lane_pipe.sv
// tb_expr_lane_pipe: directed and random checks of expr_lane_pipe against an
// integer-arithmetic lane model and a signature scoreboard.
module tb_expr_lane_pipe;
    localparam int LANES = 6;
    localparam int W = 6;
    localparam int YW = 42;
    localparam logic [5:0] MASK = 6'b111000;

    logic clk = 0, rst_n = 0, clear = 0;
    logic [31:0] sig;
    logic [15:0] count;
    int errors = 0, checks = 0, delivered = 0;
    logic [31:0] m_sig = 0;
    logic [15:0] m_cnt = 0;
    logic [YW-1:0] q[$];
    logic [YW-1:0] mon_e, yr, yh;

    expr_lane_if #(.LANES(LANES), .W(W)) bif();
    expr_lane_pipe #(.LANES(LANES), .W(W), .SIGNED_MASK(MASK), .SIG_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif), .clear_i(clear), .sig_o(sig), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [YW-1:0] model(input logic [35:0] a, input logic [35:0] b, input logic [17:0] op);
        logic [YW-1:0] r = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [5:0] ai = a[i*6 +: 6];
            logic [5:0] bi = b[i*6 +: 6];
            int va = (MASK[i] && ai[5]) ? int'(ai) - 64 : int'(ai);
            int vb = (MASK[i] && bi[5]) ? int'(bi) - 64 : int'(bi);
            int s = int'(bi[2:0]);
            int res;
            case (op[i*3 +: 3])
                3'd0: res = va + vb;
                3'd1: res = va - vb;
                3'd2: res = va & vb;
                3'd3: res = ~(va ^ vb);
                3'd4: res = va << s;
                3'd5: res = MASK[i] ? (va >>> s) : (va >> s);
                3'd6: res = (va < vb) ? 1 : 0;
                default: res = (ai == bi) ? 1 : 0;
            endcase
            r[i*7 +: 7] = res[6:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_sig = 0;
            m_cnt = 0;
        end else begin
            if (bif.out_valid && bif.out_ready) begin
                mon_e = q.size() > 0 ? q.pop_front() : 'x;
                chk("y_scoreboard", bif.y, mon_e);
                delivered++;
                if (!clear) begin
                    m_sig = {m_sig[30:0], m_sig[31]} ^ mon_e[31:0] ^ {22'b0, mon_e[41:32]};
                    m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                end
            end
            if (clear) begin
                m_sig = 0;
                m_cnt = 0;
            end
            if (bif.in_valid && bif.in_ready) q.push_back(model(bif.a, bif.b, bif.op));
        end
    end

    task automatic lane(input int i, input logic [5:0] x, input logic [5:0] z, input logic [2:0] o);
        bif.a[i*W +: W] = x;
        bif.b[i*W +: W] = z;
        bif.op[i*3 +: 3] = o;
    endtask

    task automatic zero_lanes();
        bif.a = '0;
        bif.b = '0;
        bif.op = '0;
    endtask

    task automatic rand_beat();
        bif.a = 36'({$urandom(), $urandom()});
        bif.b = 36'({$urandom(), $urandom()});
        bif.op = 18'($urandom());
    endtask

    task automatic run_beat(output logic [YW-1:0] yo);
        @(posedge clk); #1;
        chk("rdy_before_accept", bif.in_ready, 1);
        bif.in_valid = 1;
        bif.out_ready = 1;
        @(posedge clk); #1;
        bif.in_valid = 0;
        chk("latency_1cyc_empty", bif.out_valid, 0);
        @(posedge clk); #1;
        chk("latency_2cyc_valid", bif.out_valid, 1);
        yo = bif.y;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] ta[4], tbv[4];
        logic [17:0] to5[4];
        logic acc;
        int j, d0, sent;
        bif.in_valid = 0;
        bif.out_ready = 1;
        zero_lanes();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bif.in_ready, 1);
        chk("rst_out_valid", bif.out_valid, 0);
        chk("rst_y", bif.y, 0);
        chk("rst_sig", sig, 0);
        chk("rst_count", count, 0);
        rst_n = 1;

        lane(5, 6'h3D, 6'h05, 3'd0);
        run_beat(yr);
        chk("T2_add_signed", yr[35 +: 7], 7'h02);

        zero_lanes();
        lane(0, 6'h3F, 6'h01, 3'd0);
        lane(4, 6'h20, 6'h02, 3'd5);
        run_beat(yr);
        chk("T3_add_unsigned", yr[0 +: 7], 7'h40);
        chk("T3_shr_signed", yr[28 +: 7], 7'h78);

        zero_lanes();
        lane(3, 6'h3F, 6'h00, 3'd6);
        lane(1, 6'h3F, 6'h00, 3'd6);
        lane(2, 6'h15, 6'h15, 3'd7);
        lane(5, 6'h02, 6'h05, 3'd1);
        lane(0, 6'h0F, 6'h33, 3'd3);
        run_beat(yr);
        chk("T4_lt_signed", yr[21 +: 7], 7'h01);
        chk("T4_lt_unsigned", yr[7 +: 7], 7'h00);
        chk("T4_eqz", yr[14 +: 7], 7'h01);
        chk("T4_sub_signed", yr[35 +: 7], 7'h7D);
        chk("T4_xnr_unsigned", yr[0 +: 7], 7'h43);

        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            ta[k] = 36'({$urandom(), $urandom()});
            tbv[k] = 36'({$urandom(), $urandom()});
            to5[k] = 18'($urandom());
        end
        bif.out_ready = 0;
        bif.in_valid = 1;
        j = 0;
        yh = '0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) yh = bif.y;
            bif.a = ta[j]; bif.b = tbv[j]; bif.op = to5[j];
            @(negedge clk) acc = bif.in_ready;
            @(posedge clk); #1;
            if (acc) j++;
        end
        chk("T5_held_beats", j, 2);
        chk("T5_in_ready_low", bif.in_ready, 0);
        chk("T5_out_valid", bif.out_valid, 1);
        chk("T5_y_stable", bif.y, yh);
        chk("T5_y_first", bif.y, model(ta[0], tbv[0], to5[0]));
        d0 = delivered;
        bif.out_ready = 1;
        for (int k = 0; k < 20 && j < 4; k++) begin
            bif.a = ta[j]; bif.b = tbv[j]; bif.op = to5[j];
            @(negedge clk) acc = bif.in_ready;
            @(posedge clk); #1;
            if (acc) j++;
        end
        bif.in_valid = 0;
        for (int k = 0; k < 20 && delivered < d0 + 4; k++) begin
            @(posedge clk); #1;
        end
        chk("T5_delivered", delivered - d0, 4);
        chk("T5_count", count, m_cnt);
        chk("T5_sig", sig, m_sig);

        rand_beat();
        bif.in_valid = 1;
        @(posedge clk); #1;
        rand_beat();
        @(posedge clk); #1;
        bif.in_valid = 0;
        rst_n = 0;
        #1;
        chk("T1_out_valid", bif.out_valid, 0);
        chk("T1_sig", sig, 0);
        chk("T1_count", count, 0);
        chk("T1_in_ready", bif.in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        d0 = delivered;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("T1_no_stale", bif.out_valid, 0);
        end
        chk("T1_no_delivery", delivered - d0, 0);

        rand_beat();
        run_beat(yr);
        rand_beat();
        run_beat(yr);
        rand_beat();
        run_beat(yr);
        chk("T6_count_pre", count, 2);
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        chk("T6_sig_clear", sig, 0);
        chk("T6_count_clear", count, 0);
        chk("T6_drained", bif.out_valid, 0);

        sent = 0;
        rand_beat();
        for (int k = 0; k < 20000 && sent < 1000; k++) begin
            bif.in_valid = ($urandom_range(0, 4) != 0);
            bif.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk) acc = bif.in_valid && bif.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                rand_beat();
            end
        end
        bif.in_valid = 0;
        bif.out_ready = 1;
        for (int k = 0; k < 50 && q.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        chk("rand_sent", sent, 1000);
        chk("rand_count", count, 16'd1000);
        chk("rand_count_model", count, m_cnt);
        chk("rand_sig", sig, m_sig);
        chk("rand_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
